ram_initiator: RTL and testbench
================================

Name: ram_initiator

Overview:
- Command-driven initiator for the 16x4 synchronous single-port RAM in this codebase.
- Accepts single or burst read/write commands from a host over a valid/ready interface.
- Drives the RAM's addr/idata/wr/en pins and absorbs its one-cycle registered read latency.
- Returns read data on a backpressured response stream; sits between the test sequencer/host logic and the RAM instance.

Parameters:
- AW, 4, RAM address width; address arithmetic wraps mod 2^AW.
- DW, 4, RAM data width.
- LENW, 4, burst length field width; beats = cmd_len+1 (1..2^LENW).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_wr  in  1  1=write burst, 0=read burst.
- cmd_addr  in  AW  start address.
- cmd_len  in  LENW  beats minus one.
- wd_valid  in  1  write data valid.
- wd_ready  out  1  high only in WRITE.
- wd_data  in  DW  write beat data.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  DW  read beat data, registered.
- rsp_last  out  1  final beat of burst, qualified by rsp_valid.
- mem_en  out  1  to RAM en.
- mem_wr  out  1  to RAM wr.
- mem_addr  out  AW  to RAM addr.
- mem_wdata  out  DW  to RAM idata.
- mem_rdata  in  DW  from RAM odata.
- busy  out  1  high whenever state != IDLE.
- wr_err  out  1  sticky write-verify mismatch (see Optional Feature).

Behaviour:
- Reset values:
  - state=IDLE; cur_addr=0; beat=0.
  - rsp_valid=0, rsp_data=0, rsp_last=0.
  - mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - wr_err=0, busy=0.
- mem_* outputs are combinational from state, cur_addr and wd_data. mem_addr=cur_addr in all states.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cur_addr=cmd_addr, len=cmd_len, beat=0; go to WRITE if cmd_wr, else RD_ISSUE.
- WRITE:
  - wd_ready=1.
  - While wd_valid=1: mem_en=1, mem_wr=1, mem_wdata=wd_data. One beat per handshake cycle; wd_valid low stalls with mem_en=0.
  - After the handshake: if beat==len, go to IDLE; else cur_addr+1 (wrap 15->0), beat+1.
- RD_ISSUE:
  - mem_en=1, mem_wr=0 for exactly one cycle; go to RD_CAPTURE.
- RD_CAPTURE:
  - The RAM presents data in this cycle; register rsp_data=mem_rdata.
  - Set rsp_valid=1 and rsp_last=(beat==len); go to RD_RESP.
- RD_RESP:
  - Hold rsp_valid, rsp_data and rsp_last stable until rsp_ready.
  - On handshake: rsp_valid=0 next cycle. If last, go to IDLE; else increment cur_addr (wrap) and beat, go to RD_ISSUE.
- Latency:
  - Command accepted at cycle T: mem_en at T+1, rsp_valid at T+3.
  - Minimum 3 cycles per read beat.
  - Write beats: 1 cycle each when wd_valid is held high.
- Boundaries:
  - cmd_valid outside IDLE is ignored (cmd_ready=0).
  - wd_valid outside WRITE is ignored.
  - cmd_len=max gives a 16-beat burst that wraps the full array back to the start address.
- rst mid-burst:
  - Next cycle is IDLE; in-flight burst and response are discarded, with no partial rsp_last.
  - While rst is high, mem_en=0 and mem_addr=0.

Optional Feature:
- Macro: RAM_INITIATOR_WRVERIFY_EN.
- Defined:
  - After each write beat, insert WV_ISSUE (mem_en=1, mem_wr=0, same addr) and WV_CHECK (compare mem_rdata with the latched beat data).
  - A mismatch sets wr_err, which stays sticky until rst or the next command is accepted.
  - Cost: 3 cycles per write beat; wd_ready=0 during verify states.
- Undefined: no verify states; wr_err tied 0.

Test Plan:
- Reset then idle: after rst, outputs are cmd_ready=1, busy=0, mem_en=0, rsp_valid=0, wr_err=0.
- Single write then read, separate commands:
  - Write addr=5, len=0, data=A, accepted at T: mem_en=mem_wr=1, mem_addr=5 at T+1.
  - Read addr=5 accepted at T': rsp_data=A, rsp_last=1 at T'+3.
- Wrapping burst:
  - Write addr=14, len=3, data 1,2,3,4 on consecutive cycles: writes hit addresses 14,15,0,1.
  - Read of the same range returns 1,2,3,4 with rsp_last only on the 4th beat.
- Backpressure:
  - Read burst len=1 with rsp_ready low 5 cycles on beat 0: rsp_valid/rsp_data stay stable.
  - No second mem_en occurs until the handshake.
- Stalled write data: wd_valid low 2 cycles mid-burst gives mem_en=0 in those cycles and no address advance.
- Reset mid-read-burst:
  - Assert rst while in RD_RESP of a 4-beat burst.
  - Next cycle: IDLE, rsp_valid=0.
  - A new single read then completes normally.
  - With RAM_INITIATOR_WRVERIFY_EN defined, a forced mem_rdata mismatch sets wr_err=1.

Source files
------------

// File: rtl/ram_initiator.sv
// Command-driven initiator for the 16x4 synchronous single-port RAM: host valid/ready commands,
// write-data and read-response streams. Define RAM_INITIATOR_WRVERIFY_EN for write read-back checks.
module ram_initiator #(
  parameter int unsigned AW   = 4,
  parameter int unsigned DW   = 4,
  parameter int unsigned LENW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_wr,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LENW-1:0] cmd_len,
  input  logic            wd_valid,
  output logic            wd_ready,
  input  logic [DW-1:0]   wd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_last,
  output logic            mem_en,
  output logic            mem_wr,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic            wr_err
);

  typedef enum logic [2:0] {
    StIdle, StWrite, StRdIssue, StRdCapture, StRdResp, StWvIssue, StWvCheck
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cur_addr_q, cur_addr_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] beat_q, beat_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_last_q, rsp_last_d;
  logic            last_beat;

`ifdef RAM_INITIATOR_WRVERIFY_EN
  logic            wr_err_q, wr_err_d;
  logic [DW-1:0]   wv_data_q, wv_data_d;
`endif

  assign last_beat = (beat_q == len_q);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
`ifdef RAM_INITIATOR_WRVERIFY_EN
    wr_err_d    = wr_err_q;
    wv_data_d   = wv_data_q;
`endif
    cmd_ready   = 1'b0;
    wd_ready    = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_wdata   = '0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_d = cmd_addr;
          len_d      = cmd_len;
          beat_d     = '0;
`ifdef RAM_INITIATOR_WRVERIFY_EN
          wr_err_d   = 1'b0;
`endif
          state_d    = cmd_wr ? StWrite : StRdIssue;
        end
      end
      StWrite: begin
        wd_ready = 1'b1;
        if (wd_valid) begin
          mem_en    = 1'b1;
          mem_wr    = 1'b1;
          mem_wdata = wd_data;
`ifdef RAM_INITIATOR_WRVERIFY_EN
          wv_data_d = wd_data;
          state_d   = StWvIssue;
`else
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            cur_addr_d = cur_addr_q + AW'(1);
            beat_d     = beat_q + LENW'(1);
          end
`endif
        end
      end
      StWvIssue: begin
        mem_en  = 1'b1;
        state_d = StWvCheck;
      end
      StWvCheck: begin
`ifdef RAM_INITIATOR_WRVERIFY_EN
        if (mem_rdata != wv_data_q) wr_err_d = 1'b1;
`endif
        if (last_beat) begin
          state_d = StIdle;
        end else begin
          cur_addr_d = cur_addr_q + AW'(1);
          beat_d     = beat_q + LENW'(1);
          state_d    = StWrite;
        end
      end
      StRdIssue: begin
        mem_en  = 1'b1;
        state_d = StRdCapture;
      end
      StRdCapture: begin
        // RAM output is valid exactly one cycle after the issue cycle.
        rsp_data_d  = mem_rdata;
        rsp_valid_d = 1'b1;
        rsp_last_d  = last_beat;
        state_d     = StRdResp;
      end
      StRdResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (rsp_last_q) begin
            state_d = StIdle;
          end else begin
            cur_addr_d = cur_addr_q + AW'(1);
            beat_d     = beat_q + LENW'(1);
            state_d    = StRdIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Keep the RAM quiet while reset is held, whatever state we were in.
    if (rst) begin
      mem_en = 1'b0;
      mem_wr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
`ifdef RAM_INITIATOR_WRVERIFY_EN
      wr_err_q    <= 1'b0;
      wv_data_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
`ifdef RAM_INITIATOR_WRVERIFY_EN
      wr_err_q    <= wr_err_d;
      wv_data_q   <= wv_data_d;
`endif
    end
  end

  assign mem_addr  = rst ? '0 : cur_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign busy      = (state_q != StIdle);
`ifdef RAM_INITIATOR_WRVERIFY_EN
  assign wr_err    = wr_err_q;
`else
  assign wr_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ram_initiator.sv
// Self-checking bench for ram_initiator with a behavioural 16x4 registered-read RAM and
// scoreboard queues for RAM writes and read responses.
module tb_ram_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [3:0] cmd_addr, cmd_len;
  logic       wd_valid, wd_ready;
  logic [3:0] wd_data;
  logic       rsp_valid, rsp_ready, rsp_last;
  logic [3:0] rsp_data;
  logic       mem_en, mem_wr;
  logic [3:0] mem_addr, mem_wdata, mem_rdata;
  logic       busy, wr_err;

  int total = 0;
  int bad   = 0;
  int exp_wr[$];   // addr*16 + data
  int exp_rsp[$];  // last*16 + data
  logic [3:0] ram [16];
  logic [3:0] ref_mem [16];
  logic [3:0] wbuf [16];
  logic corrupt = 1'b0;

  always #5 clk = ~clk;

  ram_initiator #(.AW(4), .DW(4), .LENW(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .wr_err(wr_err)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr] ^ (corrupt ? 4'hF : 4'h0);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every RAM write and every response handshake is matched against the scoreboard.
  always @(negedge clk) begin
    int e;
    if (!rst) begin
      if (mem_en && mem_wr) begin
        if (exp_wr.size() == 0) chk("wr_extra", 1, 0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", mem_addr, e >> 4);
          chk("wr_data", mem_wdata, e & 15);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) chk("rsp_extra", 1, 0);
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_data", rsp_data, e & 15);
          chk("rsp_last", rsp_last, e >> 4);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
    step();
  endtask

  task automatic send_cmd(input logic wr, input int addr, input int len);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = 4'(addr);
    cmd_len   = 4'(len);
    @(negedge clk);
    chk("cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input int addr, input int len, input int stall_beat);
    int a, n;
    logic hs;
    send_cmd(1'b1, addr, len);
    for (int i = 0; i <= len; i++) begin
      a = (addr + i) % 16;
      if (i == stall_beat) begin
        n = 0;
        @(negedge clk);
        while (!wd_ready && n < 10) begin
          @(negedge clk);
          n++;
        end
        step();
        repeat (2) begin
          @(negedge clk);
          chk("stall_en", mem_en, 0);
          chk("stall_addr", mem_addr, a);
          step();
        end
      end
      exp_wr.push_back(a * 16 + int'(wbuf[i]));
      ref_mem[a] = wbuf[i];
      wd_valid = 1'b1;
      wd_data  = wbuf[i];
      n = 0;
      do begin
        @(negedge clk);
        if (i == 0 && n == 0) chk("wr_latency", {mem_en, mem_wr, mem_addr}, 48 + a);
        hs = wd_ready;
        step();
        n++;
      end while (!hs && n < 20);
      if (!hs) chk("wd_handshake", 0, 1);
      wd_valid = 1'b0;
    end
    wait_idle("wr_idle");
    chk("wr_queue", exp_wr.size(), 0);
  endtask

  task automatic do_read(input int addr, input int len, input int hold);
    int c;
    logic [3:0] d0;
    for (int i = 0; i <= len; i++)
      exp_rsp.push_back((i == len ? 16 : 0) + int'(ref_mem[(addr + i) % 16]));
    rsp_ready = (hold == 0);
    send_cmd(1'b0, addr, len);
    c = 1;
    forever begin
      @(negedge clk);
      if (c == 1) chk("rd_issue", {mem_en, mem_wr}, 2);
      if (rsp_valid || c >= 10) break;
      step();
      c++;
    end
    chk("rd_latency", c, 3);
    if (hold > 0) begin
      d0 = rsp_data;
      for (int k = 0; k < hold; k++) begin
        step();
        if (k == 0) begin
          cmd_valid = 1'b1;
          cmd_wr    = 1'b1;
          wd_valid  = 1'b1;
        end
        @(negedge clk);
        chk("bp_valid", rsp_valid, 1);
        chk("bp_data", rsp_data, d0);
        chk("bp_mem_en", mem_en, 0);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_wd_ready", wd_ready, 0);
      end
      step();
      cmd_valid = 1'b0;
      wd_valid  = 1'b0;
      rsp_ready = 1'b1;
    end
    wait_idle("rd_idle");
    chk("rsp_queue", exp_rsp.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp", {rsp_valid, rsp_last, rsp_data}, 0);
    chk("rst_wr_err", wr_err, 0);
    step();

    wbuf[0] = 4'hA;
    do_write(5, 0, -1);
    do_read(5, 0, 0);

    for (int i = 0; i < 4; i++) wbuf[i] = 4'(i + 1);
    do_write(14, 3, -1);
    do_read(14, 3, 0);

    for (int i = 0; i < 16; i++) wbuf[i] = 4'(15 - i);
    do_write(7, 15, -1);
    do_read(7, 15, 0);

    do_read(14, 1, 5);

    for (int i = 0; i < 4; i++) wbuf[i] = 4'(i * 3 + 2);
    do_write(3, 3, 2);
    do_read(3, 3, 0);

    // Reset in the middle of a held read response.
    for (int i = 0; i < 4; i++) wbuf[i] = 4'(9 + i);
    do_write(8, 3, -1);
    rsp_ready = 1'b0;
    send_cmd(1'b0, 8, 3);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rsp_valid", rsp_valid, 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp", {rsp_valid, rsp_last}, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    step();
    rsp_ready = 1'b1;
    do_read(9, 0, 0);

`ifdef RAM_INITIATOR_WRVERIFY_EN
    corrupt = 1'b1;
    wbuf[0] = 4'h6;
    do_write(2, 0, -1);
    chk("wv_err_set", wr_err, 1);
    corrupt = 1'b0;
    do_write(2, 0, -1);
    chk("wv_err_clear", wr_err, 0);
`else
    chk("wr_err_tied", wr_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
